// File: rtl/mem_data_initiator_if.sv
// Handshake and memory bundle for the data-side memory initiator.
// master: the initiator; slave: the LSU/memory environment.
interface mem_data_initiator_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  pLsu_bReqValid;
  logic                  pLsu_bReqReady;
  logic                  pLsu_bReqWr;
  logic [ADDR_WIDTH-1:0] pLsu_bReqAddr;
  logic [DATA_WIDTH-1:0] pLsu_bReqWrData;
  logic [1:0]            pLsu_bReqSize;
  logic                  pLsu_bReqSigned;
  logic                  pLsu_bRespValid;
  logic                  pLsu_bRespReady;
  logic [DATA_WIDTH-1:0] pLsu_bRespData;
  logic                  pLsu_bRespErr;
  logic                  pMemData_pRd_bEn;
  logic [ADDR_WIDTH-1:0] pMemData_pRd_bAddr;
  logic [DATA_WIDTH-1:0] pMemData_pRd_bData;
  logic                  pMemData_pWr_bEn;
  logic [ADDR_WIDTH-1:0] pMemData_pWr_bAddr;
  logic [DATA_WIDTH-1:0] pMemData_pWr_bData;
  logic                  pMemData_pWr_bMask_0;
  logic                  pMemData_pWr_bMask_1;
  logic                  pMemData_pWr_bMask_2;
  logic                  pMemData_pWr_bMask_3;

  modport master (
    input  pLsu_bReqValid, pLsu_bReqWr,
    input  pLsu_bReqAddr, pLsu_bReqWrData,
    input  pLsu_bReqSize, pLsu_bReqSigned,
    input  pLsu_bRespReady, pMemData_pRd_bData,
    output pLsu_bReqReady, pLsu_bRespValid,
    output pLsu_bRespData, pLsu_bRespErr,
    output pMemData_pRd_bEn, pMemData_pRd_bAddr,
    output pMemData_pWr_bEn, pMemData_pWr_bAddr,
    output pMemData_pWr_bData,
    output pMemData_pWr_bMask_0, pMemData_pWr_bMask_1,
    output pMemData_pWr_bMask_2, pMemData_pWr_bMask_3
  );

  modport slave (
    output pLsu_bReqValid, pLsu_bReqWr,
    output pLsu_bReqAddr, pLsu_bReqWrData,
    output pLsu_bReqSize, pLsu_bReqSigned,
    output pLsu_bRespReady, pMemData_pRd_bData,
    input  pLsu_bReqReady, pLsu_bRespValid,
    input  pLsu_bRespData, pLsu_bRespErr,
    input  pMemData_pRd_bEn, pMemData_pRd_bAddr,
    input  pMemData_pWr_bEn, pMemData_pWr_bAddr,
    input  pMemData_pWr_bData,
    input  pMemData_pWr_bMask_0, pMemData_pWr_bMask_1,
    input  pMemData_pWr_bMask_2, pMemData_pWr_bMask_3
  );
endinterface

// File: rtl/mem_data_initiator.sv
// Data-side memory initiator: one load/store per handshake, IDLE->ACCESS->RESP.
// Ports: clock, reset_n (async low), bus (master). Macro: MEM_INITIATOR_MISALIGN_CHECK_EN.
module mem_data_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mem_data_initiator_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  misal;
  logic [DATA_WIDTH-1:0] wdata_m;
  logic [DATA_WIDTH-1:0] rd_ext;
  logic [3:0]            mask;
  logic                  rd_en;
  logic                  wr_en;

`ifdef MEM_INITIATOR_MISALIGN_CHECK_EN
  always_comb begin
    misal = 1'b0;
    unique case (1'b1)
      (bus.pLsu_bReqSize == 2'd0): misal = 1'b0;
      (bus.pLsu_bReqSize == 2'd1): misal = bus.pLsu_bReqAddr[0];
      default:                     misal = |bus.pLsu_bReqAddr[1:0];
    endcase
  end
`else
  assign misal = 1'b0;
`endif

  // Size-based shaping; mask is {_0,_1,_2,_3}, _3 = LSB lane.
  always_comb begin
    wdata_m = data_q;
    rd_ext  = bus.pMemData_pRd_bData;
    mask    = 4'b1111;
    unique case (1'b1)
      (size_q == 2'd0): begin
        wdata_m = {{(DATA_WIDTH-8){1'b0}}, data_q[7:0]};
        rd_ext  = {{(DATA_WIDTH-8){sgn_q & bus.pMemData_pRd_bData[7]}},
                   bus.pMemData_pRd_bData[7:0]};
        mask    = 4'b0001;
      end
      (size_q == 2'd1): begin
        wdata_m = {{(DATA_WIDTH-16){1'b0}}, data_q[15:0]};
        rd_ext  = {{(DATA_WIDTH-16){sgn_q & bus.pMemData_pRd_bData[15]}},
                   bus.pMemData_pRd_bData[15:0]};
        mask    = 4'b0011;
      end
      default: ;
    endcase
  end

  assign rd_en = (state_q == S_ACCESS) & ~wr_q & ~err_q;
  assign wr_en = (state_q == S_ACCESS) & wr_q & ~err_q;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    bus.pLsu_bReqReady  = 1'b0;
    bus.pLsu_bRespValid = 1'b0;
    bus.pLsu_bRespData  = '0;
    bus.pLsu_bRespErr   = 1'b0;

    bus.pMemData_pRd_bEn     = rd_en;
    bus.pMemData_pRd_bAddr   = rd_en ? addr_q : '0;
    bus.pMemData_pWr_bEn     = wr_en;
    bus.pMemData_pWr_bAddr   = wr_en ? addr_q : '0;
    bus.pMemData_pWr_bData   = wr_en ? wdata_m : '0;
    bus.pMemData_pWr_bMask_0 = wr_en & mask[3];
    bus.pMemData_pWr_bMask_1 = wr_en & mask[2];
    bus.pMemData_pWr_bMask_2 = wr_en & mask[1];
    bus.pMemData_pWr_bMask_3 = wr_en & mask[0];

    unique case (state_q)
      S_IDLE: begin
        bus.pLsu_bReqReady = 1'b1;
        if (bus.pLsu_bReqValid) begin
          wr_d    = bus.pLsu_bReqWr;
          addr_d  = bus.pLsu_bReqAddr;
          data_d  = bus.pLsu_bReqWrData;
          size_d  = bus.pLsu_bReqSize;
          sgn_d   = bus.pLsu_bReqSigned;
          err_d   = misal;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Stores and faulted accesses answer with zero data.
        rdata_d = rd_en ? rd_ext : '0;
        state_d = S_RESP;
      end
      S_RESP: begin
        bus.pLsu_bRespValid = 1'b1;
        bus.pLsu_bRespData  = rdata_q;
        bus.pLsu_bRespErr   = err_q;
        if (bus.pLsu_bRespReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= 2'd0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: doc/mem_data_initiator.md
# mem_data_initiator

Data-side memory initiator between the CPU load/store stage and the dual-port data memory. Accepts one load or store per handshake, drives the `pMemData_pRd_*` and `pMemData_pWr_*` port group, and returns a response with the loaded value. Read data is sign- or zero-extended, and store data is masked by access size. The block has one outstanding access at a time and a fixed single memory cycle per access.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, data width; only 32 is supported

Ports:
- `clock`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `pLsu_bReqValid`  in  1  request valid
- `pLsu_bReqReady`  out  1  request ready
- `pLsu_bReqWr`  in  1  1 = store, 0 = load
- `pLsu_bReqAddr`  in  ADDR_WIDTH  byte address
- `pLsu_bReqWrData`  in  DATA_WIDTH  store data, low-aligned
- `pLsu_bReqSize`  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- `pLsu_bReqSigned`  in  1  sign-extend load result
- `pLsu_bRespValid`  out  1  response valid
- `pLsu_bRespReady`  in  1  response ready
- `pLsu_bRespData`  out  DATA_WIDTH  load result; 0 for stores
- `pLsu_bRespErr`  out  1  misaligned access
- `pMemData_pRd_bEn`  out  1  read enable
- `pMemData_pRd_bAddr`  out  ADDR_WIDTH  read address
- `pMemData_pRd_bData`  in  DATA_WIDTH  word at read address, addressed byte in bits [7:0]
- `pMemData_pWr_bEn`  out  1  write enable
- `pMemData_pWr_bAddr`  out  ADDR_WIDTH  write address
- `pMemData_pWr_bData`  out  DATA_WIDTH  write data, low-aligned
- `pMemData_pWr_bMask_0` .. `_3`  out  1 each  byte mask; `_3` is the least-significant byte

## Operation
- FSM states:
  - IDLE: `pLsu_bReqReady`=1. On valid&ready, register wr, addr, data, size, signed and err, then go to ACCESS.
  - ACCESS: exactly one cycle. Memory port enables are driven from the registers. At the cycle's closing edge, capture and extend the read data, then go to RESP.
  - RESP: `pLsu_bRespValid`=1 and response outputs are held stable. On `pLsu_bRespReady`=1, go to IDLE.
- Load in ACCESS: `pRd_bEn`=1 and `pRd_bAddr`=addr.
  - Byte result: `pRd_bData[7:0]`.
  - Half result: `pRd_bData[15:0]`.
  - Word result: the full word.
  - Extension: sign-extend if signed, else zero-extend; signed is ignored for word.
- Store in ACCESS: `pWr_bEn`=1, `pWr_bAddr`=addr.
  - `pWr_bData` = store data with bits above the access size forced to 0.
  - Mask `{_0,_1,_2,_3}`: byte 0001, half 0011, word 1111.
- Outside ACCESS, both enables, both addresses, write data and mask are 0.
- Misalignment: a half access with addr[0]=1, or a word access with addr[1:0]≠0, sets err. In ACCESS with err, both enables stay 0. The response carries err=1 and data=0.
- Store responses: data=0, err as computed.
- Reads and writes are never enabled in the same cycle.

## Timing
- Reset: all outputs are 0 except `pLsu_bReqReady`=1; state is IDLE.
- Asserting `reset_n`=0 in ACCESS or RESP:
  - enables drop immediately and the state returns to IDLE;
  - the in-flight access and its response are discarded;
  - a store already in ACCESS may or may not have committed.
- Latency: request handshake at edge E0, memory driven during cycle E0→E1, response valid from E1. Minimum 2 cycles from request handshake to response handshake.
- Throughput: with `pLsu_bRespReady` held at 1, one access every 3 cycles; ready is low in ACCESS and RESP.
- A request presented while not in IDLE is not accepted; the requester holds it.
- Response backpressure: outputs stay stable and no memory activity occurs while RESP stalls.

## Configuration
- `MEM_INITIATOR_MISALIGN_CHECK_EN`
  - Defined: misalignment detection and access suppression operate as described above.
  - Undefined: `pLsu_bRespErr` is tied to 0. Every access goes to memory with the unmodified address and the size-based mask, regardless of alignment.

## Test plan
- Word store at addr 0x80000010, data 0xDEADBEEF, then word load at the same address.
  - Store: mask 1111, write data 0xDEADBEEF for one cycle.
  - Load: response 0xDEADBEEF, err=0, two cycles after the load handshake.
- Byte store of data 0x12345680 at 0x80000003: write data 0x00000080, mask 0001.
  - Signed byte load at 0x80000003 with memory returning 0x00000080 in [7:0]: response 0xFFFFFF80.
  - Same load unsigned: response 0x00000080.
- Signed half load at 0x80000002 with memory returning 0x0000_8001: response 0xFFFF8001.
- Word load at 0x80000002 with the macro defined: no read enable, response err=1, data=0.
  - Macro undefined: read enable with addr 0x80000002, err=0.
- Hold `pLsu_bRespReady`=0 for 5 cycles after a load:
  - response stays stable and ready stays 0;
  - a second request is accepted only in the cycle after the response handshake.
- Assert `reset_n` low during ACCESS of a store: `pWr_bEn` drops immediately, ready=1 after release, no response is produced.
